// File: rtl/unit_sram_param.sv
// rtl/unit_sram_param.sv - parametrised configurable-width SRAM with RMW narrow writes
//
// Purpose: DATA_W x DEPTH SRAM accessed in words of W = DATA_W>>c bits.
//   Full-row writes (c=0) complete in one cycle. Narrow writes use a
//   read-modify-write sequence, and ready is low while it runs. Reads are
//   pipelined with latency 1, or latency 2 when the output register is on.
//
// Ports:
//   sram_clk  in   clock, posedge only
//   rst       in   synchronous active-high reset
//   wen, ren  in   write / read request (wen wins when both are high)
//   reg_out   in   1 = registered output (latency 2)
//   c         in   word width select, W = DATA_W>>c, legal when c<=SEL_W
//   addr      in   word address in units of W bits
//   d_in      in   write data, LSB-aligned
//   ready     out  request accepted on posedge when (wen|ren)&ready
//   d_out     out  read word, zero-extended
//   rd_valid  out  1-cycle pulse per read result
//   cfg_err   out  1-cycle pulse when a request with illegal c is dropped

module unit_sram_param #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  localparam int ROW_W  = $clog2(DEPTH),
  localparam int SEL_W  = $clog2(DATA_W),
  localparam int C_W    = $clog2(SEL_W + 1),
  localparam int ADDR_W = ROW_W + SEL_W
) (
  input  logic              sram_clk,
  input  logic              rst,
  input  logic              wen,
  input  logic              ren,
  input  logic              reg_out,
  input  logic [C_W-1:0]    c,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic              ready,
  output logic [DATA_W-1:0] d_out,
  output logic              rd_valid,
  output logic              cfg_err
);

  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;

  // LSB-aligned mask of W bits. An illegal c gives W=0 and an empty mask.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [C_W-1:0] cc);
    int w;
    w = DATA_W >> cc;
    return {DATA_W{1'b1}} >> (DATA_W - w);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic              cfg_reg_out;

  // request decode
  logic              req, c_ok, acc, acc_wr, acc_rd;
  logic [ADDR_W-1:0] a_sh, sub_full;
  logic [ROW_W-1:0]  row;
  logic [SEL_W-1:0]  off;
  logic [DATA_W-1:0] mask, sh_mask, sh_data;
  logic              unused_addr;

  // RMW context
  logic [ROW_W-1:0]  r_row;
  logic [DATA_W-1:0] r_mask, r_data, merge;

  // read pipeline
  logic              p_valid, s1_valid;
  logic [ROW_W-1:0]  p_row;
  logic [SEL_W-1:0]  p_off;
  logic [C_W-1:0]    p_c;
  logic [DATA_W-1:0] s1_data, rd_lane;

  // memory write port
  logic              mem_we;
  logic [ROW_W-1:0]  mem_row;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    req      = (wen | ren) & ready;
    c_ok     = (c <= C_W'(SEL_W));
    acc      = req & c_ok;
    acc_wr   = acc & wen;
    acc_rd   = acc & ~wen;
    a_sh     = addr >> c;
    row      = a_sh[ROW_W-1:0];
    sub_full = addr & ~({ADDR_W{1'b1}} << c);
    // sub < 2^c, so sub*W = sub << (SEL_W-c) always fits in SEL_W bits.
    off      = sub_full[SEL_W-1:0] << (SEL_W - int'(c));
    mask     = lane_mask(c);
    sh_mask  = mask << off;
    sh_data  = (d_in & mask) << off;
    rd_lane  = (mem[p_row] >> p_off) & lane_mask(p_c);
  end

  // Address bits above the row index are ignored.
  assign unused_addr = ^{a_sh[ADDR_W-1:ROW_W], sub_full[ADDR_W-1:SEL_W]};

  always_comb begin
    mem_we    = 1'b0;
    mem_row   = row;
    mem_wdata = d_in;
    if (state == RMW_WR) begin
      mem_we    = 1'b1;
      mem_row   = r_row;
      mem_wdata = merge;
    end else if (acc_wr && c == '0) begin
      mem_we = 1'b1;
    end
    // A reset mid-RMW drops the pending merged write.
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge sram_clk) begin
    if (mem_we) mem[mem_row] <= mem_wdata;
  end

  always_ff @(posedge sram_clk) begin
    if (rst) begin
      state       <= IDLE;
      ready       <= 1'b0;
      cfg_reg_out <= 1'b0;
      cfg_err     <= 1'b0;
      rd_valid    <= 1'b0;
      d_out       <= '0;
      p_valid     <= 1'b0;
      p_row       <= '0;
      p_off       <= '0;
      p_c         <= '0;
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      r_row       <= '0;
      r_mask      <= '0;
      r_data      <= '0;
      merge       <= '0;
    end else begin
      cfg_err  <= req & ~c_ok;
      rd_valid <= 1'b0;
      s1_valid <= 1'b0;

      p_valid <= acc_rd;
      if (acc_rd) begin
        p_row <= row;
        p_off <= off;
        p_c   <= c;
      end

      // cfg_reg_out cannot change while a read is in flight, so the
      // stage-1 and output-register paths never deliver on the same edge.
      if (p_valid) begin
        if (cfg_reg_out) begin
          s1_data  <= rd_lane;
          s1_valid <= 1'b1;
        end else begin
          d_out    <= rd_lane;
          rd_valid <= 1'b1;
        end
      end
      if (s1_valid) begin
        d_out    <= s1_data;
        rd_valid <= 1'b1;
      end

      if (!acc && !p_valid && !s1_valid) cfg_reg_out <= reg_out;

      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (acc_wr && c != '0) begin
            r_row  <= row;
            r_mask <= sh_mask;
            r_data <= sh_data;
            ready  <= 1'b0;
            state  <= RMW_RD;
          end
        end
        RMW_RD: begin
          merge <= (mem[r_row] & ~r_mask) | r_data;
          state <= RMW_WR;
        end
        RMW_WR: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unit_sram_param.sv
// tb/tb_unit_sram_param.sv - directed self-checking bench for unit_sram_param

module tb_unit_sram_param;

  logic        sram_clk = 1'b0;
  logic        rst = 1'b1;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic        reg_out = 1'b0;
  logic [2:0]  c = '0;
  logic [14:0] addr = '0;
  logic [31:0] d_in = '0;
  logic        ready;
  logic [31:0] d_out;
  logic        rd_valid;
  logic        cfg_err;

  int total = 0;
  int bad = 0;

  unit_sram_param dut (
    .sram_clk (sram_clk),
    .rst      (rst),
    .wen      (wen),
    .ren      (ren),
    .reg_out  (reg_out),
    .c        (c),
    .addr     (addr),
    .d_in     (d_in),
    .ready    (ready),
    .d_out    (d_out),
    .rd_valid (rd_valid),
    .cfg_err  (cfg_err)
  );

  always #5 sram_clk = ~sram_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sram_clk);
    #1;
  endtask

  // Issue one write; for narrow writes also wait out the RMW sequence.
  task automatic do_write(input logic [2:0] cc, input logic [14:0] a, input logic [31:0] d);
    c = cc; addr = a; d_in = d; wen = 1'b1;
    tick();
    wen = 1'b0;
    if (cc != 3'd0) begin
      tick();
      tick();
    end
  endtask

  // Issue one read with reg_out=0 and return outputs one cycle after accept.
  task automatic do_read(input logic [2:0] cc, input logic [14:0] a,
                         output logic v, output logic [31:0] d);
    c = cc; addr = a; ren = 1'b1;
    tick();
    ren = 1'b0;
    tick();
    v = rd_valid;
    d = d_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (d_out !== 32'h0) begin bad++; $display("FAIL reset_d_out got=%h exp=%h", d_out, 32'h0); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low got=%b exp=0", ready); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    rst = 1'b0;
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready_high got=%b exp=1", ready); end
  endtask

  task automatic test_full_word();
    logic v; logic [31:0] d;
    do_write(3'd0, 15'd5, 32'hDEADBEEF);
    do_read(3'd0, 15'd5, v, d);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL full_rd_valid got=%b exp=1", v); end
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL full_d_out got=%h exp=%h", d, 32'hDEADBEEF); end
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL full_rd_valid_pulse got=%b exp=0", rd_valid); end
    total++; if (d_out !== 32'hDEADBEEF) begin bad++; $display("FAIL full_d_out_hold got=%h exp=%h", d_out, 32'hDEADBEEF); end
  endtask

  task automatic test_rmw();
    logic v; logic [31:0] d;
    do_write(3'd0, 15'd0, 32'h0);
    c = 3'd2; addr = 15'd3; d_in = 32'h000000A5; wen = 1'b1;
    tick();
    wen = 1'b0;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rmw_ready_e0 got=%b exp=0", ready); end
    tick();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rmw_ready_e1 got=%b exp=0", ready); end
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rmw_ready_e2 got=%b exp=1", ready); end
    do_read(3'd0, 15'd0, v, d);
    total++; if (v !== 1'b1 || d !== 32'hA5000000) begin bad++; $display("FAIL rmw_row0 got=%b/%h exp=1/%h", v, d, 32'hA5000000); end
    do_read(3'd2, 15'd3, v, d);
    total++; if (v !== 1'b1 || d !== 32'h000000A5) begin bad++; $display("FAIL rmw_lane3 got=%b/%h exp=1/%h", v, d, 32'h000000A5); end
    do_read(3'd2, 15'd0, v, d);
    total++; if (v !== 1'b1 || d !== 32'h00000000) begin bad++; $display("FAIL rmw_lane0 got=%b/%h exp=1/%h", v, d, 32'h0); end
  endtask

  task automatic test_one_bit();
    logic v; logic [31:0] d;
    do_write(3'd0, 15'd1, 32'h0);
    do_write(3'd5, 15'd33, 32'h1);
    do_read(3'd5, 15'd32, v, d);
    total++; if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL bit_addr32 got=%b/%h exp=1/%h", v, d, 32'h0); end
    do_read(3'd5, 15'd33, v, d);
    total++; if (v !== 1'b1 || d !== 32'h1) begin bad++; $display("FAIL bit_addr33 got=%b/%h exp=1/%h", v, d, 32'h1); end
    do_read(3'd0, 15'd1, v, d);
    total++; if (v !== 1'b1 || d !== 32'h2) begin bad++; $display("FAIL bit_row1 got=%b/%h exp=1/%h", v, d, 32'h2); end
  endtask

  task automatic test_write_first();
    c = 3'd0; addr = 15'd7; d_in = 32'h12345678; wen = 1'b1;
    tick();
    wen = 1'b0; ren = 1'b1;
    tick();
    ren = 1'b0;
    tick();
    total++; if (rd_valid !== 1'b1 || d_out !== 32'h12345678) begin bad++; $display("FAIL write_first got=%b/%h exp=1/%h", rd_valid, d_out, 32'h12345678); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [4];
    logic        exp_v;
    for (int i = 0; i < 4; i++) begin
      exp_d[i] = 32'hA0A00000 + 32'(i * 3);
      do_write(3'd0, 15'(10 + i), exp_d[i]);
    end
    reg_out = 1'b1;
    tick();
    tick();
    c = 3'd0;
    for (int k = 0; k < 7; k++) begin
      ren  = (k < 4);
      addr = 15'(10 + k);
      tick();
      exp_v = (k >= 2 && k <= 5);
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, ready); end
      total++; if (rd_valid !== exp_v) begin bad++; $display("FAIL b2b_rd_valid k=%0d got=%b exp=%b", k, rd_valid, exp_v); end
      if (exp_v) begin
        total++; if (d_out !== exp_d[k-2]) begin bad++; $display("FAIL b2b_d_out k=%0d got=%h exp=%h", k, d_out, exp_d[k-2]); end
      end
    end
    ren = 1'b0;
    reg_out = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_corners();
    logic v; logic [31:0] d;
    // wen & ren together is a write only
    c = 3'd0; addr = 15'd20; d_in = 32'hCAFEF00D; wen = 1'b1; ren = 1'b1;
    tick();
    wen = 1'b0; ren = 1'b0;
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL both_no_rd_e1 got=%b exp=0", rd_valid); end
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL both_no_rd_e2 got=%b exp=0", rd_valid); end
    do_read(3'd0, 15'd20, v, d);
    total++; if (v !== 1'b1 || d !== 32'hCAFEF00D) begin bad++; $display("FAIL both_written got=%b/%h exp=1/%h", v, d, 32'hCAFEF00D); end

    // illegal width
    c = 3'd6; addr = 15'd20; d_in = 32'h0; wen = 1'b1;
    tick();
    wen = 1'b0;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_pulse got=%b exp=1", cfg_err); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL cfg_err_ready got=%b exp=1", ready); end
    tick();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_clear got=%b exp=0", cfg_err); end
    do_read(3'd0, 15'd20, v, d);
    total++; if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL cfg_err_mem got=%h exp=%h", d, 32'hCAFEF00D); end

    // reset while in RMW_RD aborts the write
    c = 3'd2; addr = 15'd80; d_in = 32'h000000FF; wen = 1'b1;
    tick();
    wen = 1'b0; rst = 1'b1;
    tick();
    total++; if (ready !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rmw_outputs got=%b/%b exp=0/0", ready, rd_valid); end
    rst = 1'b0;
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_rmw_ready got=%b exp=1", ready); end
    tick();
    tick();
    do_read(3'd0, 15'd20, v, d);
    total++; if (v !== 1'b1 || d !== 32'hCAFEF00D) begin bad++; $display("FAIL rst_rmw_row got=%b/%h exp=1/%h", v, d, 32'hCAFEF00D); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_rmw();
    test_one_bit();
    test_write_first();
    test_back_to_back();
    test_corners();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
